// File: rtl/key_event_encoder.sv
// Debounces 16 scanned keys per frame, turns accepted changes into press/release
// events and queues them in a show-ahead FIFO behind a valid/ready handshake.
module key_event_encoder #(
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [15:0] key,
    input  logic        tc,
    input  logic        ev_ready,
    output logic        ev_valid,
    output logic [4:0]  ev_code,
    output logic [15:0] stable,
    output logic        pending_any
);

    localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);
    localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

    logic          tc_q;
    logic          frame_c;
    logic [CW-1:0] cnt      [16];
    logic [CW-1:0] cnt_next [16];
    logic [15:0]   stable_next;
    logic [15:0]   flip;
    logic [15:0]   pending;
    logic [15:0]   pending_next;
    logic [15:0]   push_mask;
    logic          push;
    logic [4:0]    push_data;
    logic          pop;
    logic [4:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_next;
    logic [NW-1:0] count;
    logic [NW-1:0] count_next;
    logic [4:0]    ev_code_next;

    assign frame_c = tc & ~tc_q;

    // Per-key debounce: a change is accepted after DEBOUNCE_FRAMES disagreeing frames.
    always_comb begin
        cnt_next    = cnt;
        stable_next = stable;
        flip        = '0;
        if (frame_c) begin
            for (int i = 0; i < 16; i++) begin
                if (key[i] == stable[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable_next[i] = key[i];
                    cnt_next[i]    = '0;
                    flip[i]        = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Serializer: lowest pending index wins; a full FIFO simply holds pending bits.
    always_comb begin
        push      = 1'b0;
        push_mask = '0;
        push_data = '0;
        if (count != FULL_CNT) begin
            for (int i = 15; i >= 0; i--) begin
                if (pending[i]) begin
                    push         = 1'b1;
                    push_mask    = '0;
                    push_mask[i] = 1'b1;
                    push_data    = {stable[i], 4'(i)};
                end
            end
        end
    end

    assign pop          = ev_valid & ev_ready;
    assign pending_next = (pending & ~push_mask) ^ flip;
    assign count_next   = count + NW'(push) - NW'(pop);
    assign rd_ptr_next  = rd_ptr + PW'(pop);

    // Head register: bypass the pushed entry when it becomes the only one.
    always_comb begin
        ev_code_next = ev_code;
        if (count_next != '0) begin
            if (push && ((count - NW'(pop)) == '0)) begin
                ev_code_next = push_data;
            end else begin
                ev_code_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tc_q        <= 1'b0;
            stable      <= '0;
            pending     <= '0;
            pending_any <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ev_valid    <= 1'b0;
            ev_code     <= '0;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            tc_q        <= tc;
            stable      <= stable_next;
            pending     <= pending_next;
            pending_any <= |pending_next;
            wr_ptr      <= wr_ptr + PW'(push);
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            ev_valid    <= (count_next != '0);
            ev_code     <= ev_code_next;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_key_event_encoder.sv
// Scoreboarded bench for key_event_encoder: a queue-based reference model predicts
// events; a negedge monitor compares every handshake and the status outputs.
module tb_key_event_encoder;

    localparam int unsigned DF = 3;
    localparam int unsigned FD = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [15:0] key = '0;
    logic        tc = 1'b0;
    logic        ev_ready = 1'b0;
    logic        ev_valid;
    logic [4:0]  ev_code;
    logic [15:0] stable;
    logic        pending_any;

    key_event_encoder #(.DEBOUNCE_FRAMES(DF), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .nrst(nrst), .key(key), .tc(tc), .ev_ready(ev_ready),
        .ev_valid(ev_valid), .ev_code(ev_code), .stable(stable), .pending_any(pending_any)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: debounce counts, pending set, event FIFO as a bounded queue.
    int         m_cnt [16];
    bit [15:0]  m_stable = '0;
    bit [15:0]  m_pend = '0;
    bit         m_tcq = 1'b0;
    logic [4:0] m_fifo [$];
    logic [4:0] exp_q [$];
    int         m_sz;
    bit         m_pop;
    bit         m_push;
    logic [4:0] m_code;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            m_stable = '0;
            m_pend   = '0;
            m_tcq    = 1'b0;
            m_fifo.delete();
            exp_q.delete();
        end else begin
            m_sz   = m_fifo.size();
            m_pop  = (m_sz != 0) && ev_ready;
            m_push = 1'b0;
            m_code = '0;
            if (m_pend != 0 && m_sz < FD) begin
                for (int i = 0; i < 16; i++) begin
                    if (m_pend[i] && !m_push) begin
                        m_push    = 1'b1;
                        m_code    = {m_stable[i], 4'(i)};
                        m_pend[i] = 1'b0;
                    end
                end
            end
            if (m_pop) void'(m_fifo.pop_front());
            if (m_push) begin
                m_fifo.push_back(m_code);
                exp_q.push_back(m_code);
            end
            if (tc && !m_tcq) begin
                for (int i = 0; i < 16; i++) begin
                    if (key[i] == m_stable[i]) begin
                        m_cnt[i] = 0;
                    end else begin
                        m_cnt[i]++;
                        if (m_cnt[i] == DF) begin
                            m_stable[i] = key[i];
                            m_cnt[i]    = 0;
                            m_pend[i]   = ~m_pend[i];
                        end
                    end
                end
            end
            m_tcq = tc;
        end
    end

    // Monitor: status outputs against the model, handshakes against the scoreboard.
    logic [4:0] seen [$];
    int         seen_t [$];
    logic [4:0] want [$];
    logic [4:0] exp_head;

    always @(negedge clk) begin
        if (nrst) begin
            check("stable", 32'(stable), 32'(m_stable));
            check("ev_valid", 32'(ev_valid), 32'(m_fifo.size() != 0));
            check("pending_any", 32'(pending_any), 32'(m_pend != 0));
            if (ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got 0x%0h, expected no event (cycle %0d)", ev_code, cyc);
                end else begin
                    exp_head = exp_q.pop_front();
                    check("ev_code", 32'(ev_code), 32'(exp_head));
                end
                seen.push_back(ev_code);
                seen_t.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [15:0] k, input int hi);
        key = k;
        tc  = 1'b1;
        tick(hi);
        tc  = 1'b0;
        tick(2);
    endtask

    task automatic clear_seen();
        seen.delete();
        seen_t.delete();
    endtask

    task automatic check_seen(input string name);
        check({name, "_count"}, 32'(seen.size()), 32'(want.size()));
        for (int i = 0; i < seen.size() && i < want.size(); i++)
            check(name, 32'(seen[i]), 32'(want[i]));
    endtask

    logic [15:0] rk;
    logic [15:0] mask;
    int          n9;

    initial begin
        // Reset state
        tick(2);
        check("rst_stable", 32'(stable), 32'h0);
        check("rst_ev_valid", 32'(ev_valid), 32'h0);
        check("rst_ev_code", 32'(ev_code), 32'h0);
        check("rst_pending_any", 32'(pending_any), 32'h0);
        nrst = 1'b1;
        ev_ready = 1'b1;
        tick(2);

        // Single key press with exact latency, then release
        clear_seen();
        frame(16'h0020, 1);
        frame(16'h0020, 1);
        check("s2_not_yet", 32'(stable), 32'h0);
        key = 16'h0020;
        tc  = 1'b1;
        tick(1);
        check("s2_stable", 32'(stable), 32'h0020);
        check("s2_valid_e0", 32'(ev_valid), 32'h0);
        tc = 1'b0;
        tick(1);
        check("s2_valid_e1", 32'(ev_valid), 32'h1);
        check("s2_code_e1", 32'(ev_code), 32'h15);
        tick(1);
        check("s2_valid_e2", 32'(ev_valid), 32'h0);
        tick(3);
        for (int f = 0; f < 3; f++) frame(16'h0000, 1);
        tick(4);
        want = '{5'h15, 5'h05};
        check_seen("s2_events");

        // Bounce on key 2
        clear_seen();
        frame(16'h0004, 1);
        frame(16'h0004, 1);
        frame(16'h0000, 1);
        frame(16'h0004, 1);
        frame(16'h0004, 1);
        tick(4);
        check("s3_quiet", 32'(seen.size()), 32'h0);
        frame(16'h0004, 1);
        tick(4);
        want = '{5'h12};
        check_seen("s3_events");
        for (int f = 0; f < 3; f++) frame(16'h0000, 1);
        tick(4);

        // Simultaneous changes leave in ascending index on consecutive cycles
        clear_seen();
        for (int f = 0; f < 3; f++) frame(16'h8081, 1);
        tick(4);
        want = '{5'h10, 5'h17, 5'h1F};
        check_seen("s4_events");
        check("s4_stable", 32'(stable), 32'h8081);
        if (seen_t.size() == 3) begin
            check("s4_back2back_a", 32'(seen_t[1] - seen_t[0]), 32'h1);
            check("s4_back2back_b", 32'(seen_t[2] - seen_t[1]), 32'h1);
        end
        for (int f = 0; f < 3; f++) frame(16'h0000, 1);
        tick(6);

        // Backpressure: four queued, two held pending, nothing lost
        clear_seen();
        ev_ready = 1'b0;
        for (int f = 0; f < 3; f++) frame(16'h003F, 1);
        tick(8);
        check("s5_valid", 32'(ev_valid), 32'h1);
        check("s5_head", 32'(ev_code), 32'h10);
        check("s5_pending_any", 32'(pending_any), 32'h1);
        ev_ready = 1'b1;
        tick(12);
        want = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15};
        check_seen("s5_events");

        // Two-cycle strobes count once each
        clear_seen();
        frame(16'h013F, 2);
        frame(16'h013F, 2);
        check("s6_two_frames", 32'(stable[8]), 32'h0);
        frame(16'h013F, 2);
        check("s6_three_frames", 32'(stable[8]), 32'h1);
        tick(4);
        want = '{5'h18};
        check_seen("s6_strobe");

        // Key 9 press and release while blocked cancels out
        clear_seen();
        ev_ready = 1'b0;
        for (int f = 0; f < 3; f++) frame(16'h0000, 1);
        for (int f = 0; f < 3; f++) frame(16'h0200, 1);
        for (int f = 0; f < 3; f++) frame(16'h0000, 1);
        ev_ready = 1'b1;
        tick(16);
        want = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h08};
        check_seen("s6_cancel");
        n9 = 0;
        foreach (seen[i]) if (seen[i][3:0] == 4'd9) n9++;
        check("s6_key9_events", 32'(n9), 32'h0);

        // Randomized traffic
        rk = '0;
        for (int f = 0; f < 400; f++) begin
            mask = '0;
            for (int b = 0; b < 16; b++) if ($urandom_range(0, 5) == 0) mask[b] = 1'b1;
            if ($urandom_range(0, 2) == 0) rk = rk ^ mask;
            key      = rk;
            tc       = 1'b1;
            ev_ready = ($urandom_range(0, 3) != 0);
            tick($urandom_range(1, 3));
            tc       = 1'b0;
            key      = 16'($urandom);
            ev_ready = ($urandom_range(0, 2) != 0);
            tick($urandom_range(1, 4));
        end

        // Reset mid-traffic
        #3;
        nrst = 1'b0;
        #1;
        check("mid_rst_stable", 32'(stable), 32'h0);
        check("mid_rst_ev_valid", 32'(ev_valid), 32'h0);
        check("mid_rst_ev_code", 32'(ev_code), 32'h0);
        check("mid_rst_pending_any", 32'(pending_any), 32'h0);
        tick(2);
        nrst = 1'b1;
        ev_ready = 1'b1;
        clear_seen();
        frame(16'h0000, 1);
        tick(5);
        check("post_rst_no_event", 32'(seen.size()), 32'h0);

        for (int f = 0; f < 100; f++) begin
            if ($urandom_range(0, 3) == 0) rk = 16'($urandom);
            key      = rk;
            tc       = 1'b1;
            ev_ready = ($urandom_range(0, 1) != 0);
            tick($urandom_range(1, 2));
            tc = 1'b0;
            tick($urandom_range(1, 3));
        end

        // Drain whatever is still expected, within a bounded budget
        ev_ready = 1'b1;
        tc = 1'b0;
        for (int c = 0; c < 200 && (exp_q.size() != 0 || m_pend != 0); c++) tick(1);
        tick(2);
        check("drain_left", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
